// File: rtl/load_store_unit.sv
// RV64 load/store sequencer for a doubleword-only data memory.
// Sub-doubleword stores are done as read-modify-write.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [63:0] rdata,
    output logic [4:0]  mem_addr,
    output logic        mem_we,
    output logic [63:0] mem_din,
    input  logic [63:0] mem_dout
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } stateT;

    stateT       state;
    stateT       nextState;
    logic        isStoreQ;
    logic [2:0]  funct3Q;
    logic [7:0]  addrQ;
    logic [63:0] wdataQ;
    logic [63:0] mergeQ;
    logic        errQ;

    logic        reqBad;
    logic        reqSd;
    logic [5:0]  shift;
    logic [63:0] shifted;
    logic [63:0] loadVal;
    logic [7:0]  baseMask;
    logic [7:0]  byteMask;
    logic [63:0] bitMask;
    logic [63:0] merged;
    logic        unusedAddr;

    assign unusedAddr = ^addr[63:8];
    assign mem_addr   = addrQ[7:3];
    assign shift      = {addrQ[2:0], 3'b000};
    assign shifted    = mem_dout >> shift;

    // Classify the incoming request: illegal width code or misalignment.
    always_comb begin
        reqBad = 1'b0;
        if (funct3 == 3'b111 || (is_store && funct3[2])) begin
            reqBad = 1'b1;
        end else begin
            case (funct3[1:0])
                2'b01:   reqBad = addr[0];
                2'b10:   reqBad = |addr[1:0];
                2'b11:   reqBad = |addr[2:0];
                default: reqBad = 1'b0;
            endcase
        end
        reqSd = is_store && (funct3 == 3'b011);
    end

    // Pick the addressed bytes out of the doubleword and extend them.
    always_comb begin
        loadVal = shifted;
        unique case (funct3Q)
            3'b000:  loadVal = {{56{shifted[7]}}, shifted[7:0]};
            3'b001:  loadVal = {{48{shifted[15]}}, shifted[15:0]};
            3'b010:  loadVal = {{32{shifted[31]}}, shifted[31:0]};
            3'b100:  loadVal = {56'd0, shifted[7:0]};
            3'b101:  loadVal = {48'd0, shifted[15:0]};
            3'b110:  loadVal = {32'd0, shifted[31:0]};
            default: loadVal = shifted;
        endcase
    end

    // Splice the store bytes into the doubleword read back in READ.
    always_comb begin
        case (funct3Q[1:0])
            2'b00:   baseMask = 8'h01;
            2'b01:   baseMask = 8'h03;
            2'b10:   baseMask = 8'h0F;
            default: baseMask = 8'hFF;
        endcase
        byteMask = baseMask << addrQ[2:0];
        for (int k = 0; k < 8; k++) begin
            bitMask[8*k +: 8] = {8{byteMask[k]}};
        end
        merged = (mergeQ & ~bitMask) | ((wdataQ << shift) & bitMask);
    end

    // State register, request latches, merge buffer and load result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            isStoreQ <= 1'b0;
            funct3Q  <= 3'd0;
            addrQ    <= 8'd0;
            wdataQ   <= 64'd0;
            mergeQ   <= 64'd0;
            errQ     <= 1'b0;
            rdata    <= 64'd0;
        end else begin
            state <= nextState;
            if (state == IDLE && start) begin
                isStoreQ <= is_store;
                funct3Q  <= funct3;
                addrQ    <= addr[7:0];
                wdataQ   <= wdata;
                errQ     <= reqBad;
            end
            if (state == READ) begin
                if (isStoreQ) begin
                    mergeQ <= mem_dout;
                end else begin
                    rdata <= loadVal;
                end
            end
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        nextState = state;
        busy      = (state != IDLE);
        done      = 1'b0;
        err       = 1'b0;
        mem_we    = 1'b0;
        mem_din   = 64'd0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (reqBad) begin
                        nextState = DONE;
                    end else if (reqSd) begin
                        nextState = WRITE;
                    end else begin
                        nextState = READ;
                    end
                end
            end
            READ: begin
                nextState = isStoreQ ? WRITE : DONE;
            end
            WRITE: begin
                mem_we    = 1'b1;
                mem_din   = merged;
                nextState = DONE;
            end
            default: begin
                done      = 1'b1;
                err       = errQ;
                nextState = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural
// 32 x 64 data memory attached to its doubleword port.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [63:0] addr = 64'd0;
    logic [63:0] wdata = 64'd0;
    logic        busy;
    logic        done;
    logic        err;
    logic [63:0] rdata;
    logic [4:0]  mem_addr;
    logic        mem_we;
    logic [63:0] mem_din;
    logic [63:0] mem_dout;

    logic [63:0] mem [32];

    int          checks = 0;
    int          failures = 0;

    int          doneCyc;
    int          doneCnt;
    logic        errAtDone;
    logic [63:0] rdataAtDone;
    logic [7:0]  weMask;
    logic [4:0]  addrC1;
    logic        busyC1;

    load_store_unit dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .is_store (is_store),
        .funct3   (funct3),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    always #5 clk = ~clk;

    assign mem_dout = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_din;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Issue one request and observe cycles 1..6 after the start edge.
    task automatic issue(input logic st, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] wd);
        @(negedge clk);
        is_store = st;
        funct3   = f3;
        addr     = a;
        wdata    = wd;
        start    = 1'b1;
        @(posedge clk);
        doneCyc     = -1;
        doneCnt     = 0;
        weMask      = 8'd0;
        errAtDone   = 1'b0;
        rdataAtDone = 64'd0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start  = 1'b0;
                addrC1 = mem_addr;
                busyC1 = busy;
            end
            if (mem_we) weMask[c] = 1'b1;
            if (done) begin
                doneCnt++;
                if (doneCyc < 0) begin
                    doneCyc     = c;
                    errAtDone   = err;
                    rdataAtDone = rdata;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b1;
        is_store = 1'b1;
        funct3   = 3'b011;
        addr     = 64'h10;
        wdata    = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({busy, done, err, mem_we} !== 4'b0000) begin
                failures++;
                $display("FAIL reset_ctrl got=%b exp=0000",
                         {busy, done, err, mem_we});
            end
        end
        checks++;
        if (rdata !== 64'd0) begin
            failures++;
            $display("FAIL reset_rdata got=%h exp=0", rdata);
        end
        checks++;
        if (mem_din !== 64'd0 || mem_addr !== 5'd0) begin
            failures++;
            $display("FAIL reset_mem got din=%h addr=%h exp=0",
                     mem_din, mem_addr);
        end
        reset = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_sd_ld();
        issue(1'b1, 3'b011, 64'h10, 64'h0123_4567_89AB_CDEF);
        checks++;
        if (weMask !== 8'b0000_0010) begin
            failures++;
            $display("FAIL sd_we got=%b exp=00000010", weMask);
        end
        checks++;
        if (addrC1 !== 5'd2 || busyC1 !== 1'b1) begin
            failures++;
            $display("FAIL sd_addr got=%0d busy=%b exp=2 busy=1",
                     addrC1, busyC1);
        end
        checks++;
        if (doneCyc !== 2 || errAtDone !== 1'b0 || doneCnt !== 1) begin
            failures++;
            $display("FAIL sd_done got=%0d err=%b n=%0d exp=2 err=0 n=1",
                     doneCyc, errAtDone, doneCnt);
        end
        issue(1'b0, 3'b011, 64'h10, 64'd0);
        checks++;
        if (doneCyc !== 2 || weMask !== 8'd0) begin
            failures++;
            $display("FAIL ld_done got=%0d we=%b exp=2 we=0",
                     doneCyc, weMask);
        end
        checks++;
        if (rdataAtDone !== 64'h0123_4567_89AB_CDEF) begin
            failures++;
            $display("FAIL ld_rdata got=%h exp=0123456789abcdef",
                     rdataAtDone);
        end
    endtask

    task automatic test_byte_rmw();
        issue(1'b1, 3'b000, 64'h13, 64'hFF);
        checks++;
        if (doneCyc !== 3 || weMask !== 8'b0000_0100) begin
            failures++;
            $display("FAIL sb_timing got=%0d we=%b exp=3 we=00000100",
                     doneCyc, weMask);
        end
        checks++;
        if (mem[2] !== 64'h0123_4567_FFAB_CDEF) begin
            failures++;
            $display("FAIL sb_mem got=%h exp=01234567ffabcdef", mem[2]);
        end
        issue(1'b0, 3'b000, 64'h13, 64'd0);
        checks++;
        if (rdataAtDone !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            failures++;
            $display("FAIL lb got=%h exp=ffffffffffffffff", rdataAtDone);
        end
        issue(1'b0, 3'b100, 64'h13, 64'd0);
        checks++;
        if (rdataAtDone !== 64'h0000_0000_0000_00FF) begin
            failures++;
            $display("FAIL lbu got=%h exp=00000000000000ff", rdataAtDone);
        end
    endtask

    task automatic test_extend();
        issue(1'b1, 3'b011, 64'h0, 64'h8000_0000_8000_8000);
        issue(1'b0, 3'b001, 64'h0, 64'd0);
        checks++;
        if (rdataAtDone !== 64'hFFFF_FFFF_FFFF_8000) begin
            failures++;
            $display("FAIL lh got=%h exp=ffffffffffff8000", rdataAtDone);
        end
        issue(1'b0, 3'b101, 64'h0, 64'd0);
        checks++;
        if (rdataAtDone !== 64'h0000_0000_0000_8000) begin
            failures++;
            $display("FAIL lhu got=%h exp=0000000000008000", rdataAtDone);
        end
        issue(1'b0, 3'b010, 64'h4, 64'd0);
        checks++;
        if (rdataAtDone !== 64'hFFFF_FFFF_8000_0000) begin
            failures++;
            $display("FAIL lw got=%h exp=ffffffff80000000", rdataAtDone);
        end
        issue(1'b0, 3'b110, 64'h4, 64'd0);
        checks++;
        if (rdataAtDone !== 64'h0000_0000_8000_0000) begin
            failures++;
            $display("FAIL lwu got=%h exp=0000000080000000", rdataAtDone);
        end
    endtask

    task automatic test_errors();
        issue(1'b0, 3'b010, 64'h2, 64'd0);
        checks++;
        if (doneCyc !== 1 || errAtDone !== 1'b1) begin
            failures++;
            $display("FAIL lw_mis got=%0d err=%b exp=1 err=1",
                     doneCyc, errAtDone);
        end
        checks++;
        if (rdata !== 64'h0000_0000_8000_0000 || weMask !== 8'd0) begin
            failures++;
            $display("FAIL lw_mis_hold got=%h we=%b exp=80000000 we=0",
                     rdata, weMask);
        end
        issue(1'b1, 3'b110, 64'h10, 64'h1234);
        checks++;
        if (doneCyc !== 1 || errAtDone !== 1'b1 || weMask !== 8'd0) begin
            failures++;
            $display("FAIL sw_bad got=%0d err=%b we=%b exp=1 err=1 we=0",
                     doneCyc, errAtDone, weMask);
        end
        checks++;
        if (mem[2] !== 64'h0123_4567_FFAB_CDEF) begin
            failures++;
            $display("FAIL sw_bad_mem got=%h exp=01234567ffabcdef", mem[2]);
        end
    endtask

    task automatic test_busy_start();
        int cnt;
        int dc;
        issue(1'b1, 3'b011, 64'h08, 64'd0);
        @(negedge clk);
        is_store = 1'b1;
        funct3   = 3'b000;
        addr     = 64'h08;
        wdata    = 64'h5A;
        start    = 1'b1;
        @(posedge clk);
        cnt = 0;
        dc  = -1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin
                wdata    = 64'h11;
                is_store = 1'b0;
                funct3   = 3'b011;
                addr     = 64'h10;
            end
            if (c == 4) start = 1'b0;
            if (done) begin
                cnt++;
                if (dc < 0) dc = c;
            end
        end
        checks++;
        if (cnt !== 1 || dc !== 3) begin
            failures++;
            $display("FAIL busy_start got n=%0d cyc=%0d exp n=1 cyc=3",
                     cnt, dc);
        end
        checks++;
        if (mem[1] !== 64'h5A) begin
            failures++;
            $display("FAIL busy_latch got=%h exp=5a", mem[1]);
        end
    endtask

    task automatic test_reset_midop();
        logic seenWe;
        logic seenDone;
        issue(1'b1, 3'b011, 64'h18, 64'hAAAA_AAAA_AAAA_AAAA);
        @(negedge clk);
        is_store = 1'b1;
        funct3   = 3'b000;
        addr     = 64'h18;
        wdata    = 64'h55;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL midop_busy got=%b exp=1", busy);
        end
        reset    = 1'b1;
        seenWe   = mem_we;
        seenDone = done;
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            if (c == 2) begin
                reset = 1'b0;
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL midop_idle got=%b exp=0", busy);
                end
            end
            if (mem_we) seenWe = 1'b1;
            if (done) seenDone = 1'b1;
        end
        checks++;
        if (seenWe !== 1'b0 || seenDone !== 1'b0) begin
            failures++;
            $display("FAIL midop_quiet got we=%b done=%b exp=0 0",
                     seenWe, seenDone);
        end
        checks++;
        if (mem[3] !== 64'hAAAA_AAAA_AAAA_AAAA) begin
            failures++;
            $display("FAIL midop_mem got=%h exp=aaaaaaaaaaaaaaaa", mem[3]);
        end
    endtask

    initial begin
        test_reset();
        test_sd_ld();
        test_byte_rmw();
        test_extend();
        test_errors();
        test_busy_start();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
